cache_mem_arbiter: RTL and testbench

//  Arbitrates the I-cache and D-cache miss ports onto one shared physical-memory port.

---
 rtl/cache_mem_arbiter_if.sv | 39 +++
 rtl/cache_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
//   One stb/cyc/resp/retry line-transaction port, the same shape as the
//   pipeline cache miss ports. The requester uses the master modport and the
//   responder uses the slave modport.
// Signals
//   addr   line address             (master -> slave)
//   wdata  write line               (master -> slave)
//   stb    strobe                   (master -> slave)
//   cyc    cycle valid              (master -> slave)
//   we     write enable             (master -> slave)
//   sel    byte enables             (master -> slave)
//   rdata  read line                (slave -> master)
//   resp   transaction done         (slave -> master)
//   retry  transaction must retry   (slave -> master)
interface cache_mem_arbiter_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16,
  parameter int MASK_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              stb;
  logic              cyc;
  logic              we;
  logic [MASK_W-1:0] sel;
  logic [DATA_W-1:0] rdata;
  logic              resp;
  logic              retry;

  modport master (
    output addr, wdata, stb, cyc, we, sel,
    input  rdata, resp, retry
  );

  modport slave (
    input  addr, wdata, stb, cyc, we, sel,
    output rdata, resp, retry
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one physical-memory port between the I-cache and D-cache miss
//   ports, one line transaction at a time. D-side normally wins; after
//   STARVE_MAX consecutive D grants taken while I was waiting, I wins the next
//   arbitration.
// Ports
//   clk      clock, all state on the rising edge
//   rst_n    synchronous reset, active-low
//   i_bus    I-cache miss port (slave view); wdata/we/sel are ignored, the
//            I-side only reads
//   d_bus    D-cache miss port (slave view)
//   m_bus    shared memory port (master view)
//   grant_d  1 while the D-side owns the memory port
// Optional build macro ARB_STATS_EN
//   Adds saturating 16-bit counters stat_i_grants, stat_d_grants and
//   stat_i_wait (cycles with an I request pending while I does not own the
//   port). Without it the core behaviour is identical and the ports are absent.
//
// state   | meaning
// IDLE    | no owner, arbitrate any pending request
// GRANT_I | I-side owns the memory port
// GRANT_D | D-side owns the memory port
module cache_mem_arbiter #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 16,
  parameter int MASK_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_mem_arbiter_if.slave    i_bus,
  cache_mem_arbiter_if.slave    d_bus,
  cache_mem_arbiter_if.master   m_bus,
  output logic                  grant_d
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           stat_i_grants,
  output logic [15:0]           stat_d_grants,
  output logic [15:0]           stat_i_wait
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve;
  logic       req_i;
  logic       req_d;
  logic       d_wins;
  logic       go_i;
  logic       go_d;
  logic       end_i;
  logic       end_d;

  assign req_i = i_bus.cyc & i_bus.stb;
  assign req_d = d_bus.cyc & d_bus.stb;

  // D keeps priority until I has watched STARVE_MAX D grants go by.
  assign d_wins = req_d & (~req_i | (starve < STARVE_LIM));
  assign go_d   = (state == IDLE) & d_wins;
  assign go_i   = (state == IDLE) & ~d_wins & req_i;

  // Ownership ends on completion, on retry, or when the owner abandons cyc.
  assign end_i  = m_bus.resp | m_bus.retry | ~i_bus.cyc;
  assign end_d  = m_bus.resp | m_bus.retry | ~d_bus.cyc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      starve  <= 4'd0;
      grant_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go_d) begin
            state   <= GRANT_D;
            grant_d <= 1'b1;
            if (req_i && (starve != 4'hF)) begin
              starve <= starve + 4'd1;
            end
          end else if (go_i) begin
            state   <= GRANT_I;
            grant_d <= 1'b0;
            starve  <= 4'd0;
          end
        end
        GRANT_I: begin
          if (end_i) begin
            state   <= IDLE;
            grant_d <= 1'b0;
          end
        end
        GRANT_D: begin
          if (end_d) begin
            state   <= IDLE;
            grant_d <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_d <= 1'b0;
        end
      endcase
    end
  end

  // Memory port follows the owner combinationally so a dropped cyc reaches
  // memory in the same cycle. The I-side is always a full-line read.
  always_comb begin
    m_bus.addr  = '0;
    m_bus.wdata = '0;
    m_bus.stb   = 1'b0;
    m_bus.cyc   = 1'b0;
    m_bus.we    = 1'b0;
    m_bus.sel   = '0;
    case (state)
      GRANT_I: begin
        m_bus.addr = i_bus.addr;
        m_bus.stb  = i_bus.stb;
        m_bus.cyc  = i_bus.cyc;
        m_bus.sel  = '1;
      end
      GRANT_D: begin
        m_bus.addr  = d_bus.addr;
        m_bus.wdata = d_bus.wdata;
        m_bus.stb   = d_bus.stb;
        m_bus.cyc   = d_bus.cyc;
        m_bus.we    = d_bus.we;
        m_bus.sel   = d_bus.sel;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; only the owner's resp qualifies it. Responses
  // arriving with no owner are dropped.
  assign i_bus.rdata = m_bus.rdata;
  assign d_bus.rdata = m_bus.rdata;
  assign i_bus.resp  = m_bus.resp  & (state == GRANT_I);
  assign i_bus.retry = m_bus.retry & (state == GRANT_I);
  assign d_bus.resp  = m_bus.resp  & (state == GRANT_D);
  assign d_bus.retry = m_bus.retry & (state == GRANT_D);

  logic unused_i_side;
  assign unused_i_side = ^{i_bus.wdata, i_bus.we, i_bus.sel};

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_i_grants <= 16'd0;
      stat_d_grants <= 16'd0;
      stat_i_wait   <= 16'd0;
    end else begin
      if (go_i && (stat_i_grants != 16'hFFFF)) begin
        stat_i_grants <= stat_i_grants + 16'd1;
      end
      if (go_d && (stat_d_grants != 16'hFFFF)) begin
        stat_d_grants <= stat_d_grants + 16'd1;
      end
      if (req_i && (state != GRANT_I) && (stat_i_wait != 16'hFFFF)) begin
        stat_i_wait <= stat_i_wait + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 16;
  localparam int MASK_W     = 16;
  localparam int STARVE_MAX = 3;
  localparam int N_TRANS    = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic grant_d;

  cache_mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MASK_W(MASK_W)) i_bus ();
  cache_mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MASK_W(MASK_W)) d_bus ();
  cache_mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MASK_W(MASK_W)) m_bus ();

`ifdef ARB_STATS_EN
  logic [15:0] stat_i_grants;
  logic [15:0] stat_d_grants;
  logic [15:0] stat_i_wait;
`endif

  cache_mem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MASK_W(MASK_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_bus  (i_bus),
    .d_bus  (d_bus),
    .m_bus  (m_bus),
    .grant_d(grant_d)
`ifdef ARB_STATS_EN
    ,
    .stat_i_grants(stat_i_grants),
    .stat_d_grants(stat_d_grants),
    .stat_i_wait  (stat_i_wait)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard of responses the requesters should see.
  typedef struct packed {
    logic              side;   // 1 = D
    logic              resp;
    logic              retry;
    logic [DATA_W-1:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  // Reference model: who owns the memory port, plus how many D grants the
  // I-side has watched go by while it was waiting.
  bit   model_en = 1'b0;
  int   owner = 0;   // 0 none, 1 I, 2 D
  int   nxt;
  int   credit = 0;
  int   mdl_i_grants = 0;
  int   mdl_d_grants = 0;
  int   mdl_i_wait = 0;
  logic ri, rd;
  logic [35:0] exp_ctl;
  logic [DATA_W-1:0] exp_wd;

  always @(negedge clk) begin
    if (model_en) begin
      ri = i_bus.cyc & i_bus.stb;
      rd = d_bus.cyc & d_bus.stb;
      case (owner)
        1: begin
          exp_ctl = {1'b0, i_bus.stb, i_bus.cyc, 1'b0, 16'hFFFF, i_bus.addr};
          exp_wd  = '0;
        end
        2: begin
          exp_ctl = {1'b1, d_bus.stb, d_bus.cyc, d_bus.we, d_bus.sel, d_bus.addr};
          exp_wd  = d_bus.wdata;
        end
        default: begin
          exp_ctl = '0;
          exp_wd  = '0;
        end
      endcase
      check("mdl_ctl", {grant_d, m_bus.stb, m_bus.cyc, m_bus.we, m_bus.sel, m_bus.addr}, exp_ctl);
      check("mdl_wdata", m_bus.wdata, exp_wd);
      if (owner != 0 && (m_bus.resp || m_bus.retry))
        sb.push_back({owner == 2, m_bus.resp, m_bus.retry, m_bus.rdata});
      if (owner != 1 && ri) mdl_i_wait++;
      nxt = owner;
      if (owner == 0) begin
        if (rd && (!ri || credit < STARVE_MAX)) begin
          nxt = 2;
          mdl_d_grants++;
          if (ri && credit < 15) credit++;
        end else if (ri) begin
          nxt = 1;
          mdl_i_grants++;
          credit = 0;
        end
      end else if (m_bus.resp || m_bus.retry || (owner == 1 ? !i_bus.cyc : !d_bus.cyc)) begin
        nxt = 0;
      end
      if (!rst_n) begin
        nxt = 0;
        credit = 0;
        mdl_i_grants = 0;
        mdl_d_grants = 0;
        mdl_i_wait = 0;
      end
      owner = nxt;
    end
  end

  // Monitor: every response a requester sees must match the next expectation.
  initial forever begin
    @(negedge clk);
    #1;
    if (model_en && (i_bus.resp || i_bus.retry || d_bus.resp || d_bus.retry)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got i_resp=%b i_retry=%b d_resp=%b d_retry=%b, required none",
                 i_bus.resp, i_bus.retry, d_bus.resp, d_bus.retry);
      end else begin
        e = sb.pop_front();
        check("sb_route", {i_bus.resp, i_bus.retry, d_bus.resp, d_bus.retry},
              e.side ? {2'b00, e.resp, e.retry} : {e.resp, e.retry, 2'b00});
        if (e.resp) check("sb_rdata", e.side ? d_bus.rdata : i_bus.rdata, e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit masters_done = 1'b0;

  task automatic i_master(input int n);
    int gap;
    int budget;
    bit done;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      i_bus.addr = 16'($urandom);
      i_bus.cyc  = 1'b1;
      i_bus.stb  = 1'b1;
      budget = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (i_bus.resp) done = 1'b1;
        else if (++budget > 300) begin
          vectors++;
          miscompares++;
          $display("FAIL i_master_timeout: got no i_resp in 300 cycles, required a response");
          done = 1'b1;
        end
      end
      step();
      i_bus.cyc = 1'b0;
      i_bus.stb = 1'b0;
    end
  endtask

  task automatic d_master(input int n);
    int gap;
    int budget;
    bit done;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      d_bus.addr  = 16'($urandom);
      d_bus.wdata = {$urandom, $urandom, $urandom, $urandom};
      d_bus.we    = 1'($urandom_range(0, 1));
      d_bus.sel   = 16'($urandom);
      d_bus.cyc   = 1'b1;
      d_bus.stb   = 1'b1;
      budget = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (d_bus.resp) done = 1'b1;
        else if (++budget > 300) begin
          vectors++;
          miscompares++;
          $display("FAIL d_master_timeout: got no d_resp in 300 cycles, required a response");
          done = 1'b1;
        end
      end
      step();
      d_bus.cyc = 1'b0;
      d_bus.stb = 1'b0;
    end
  endtask

  task automatic mem_slave();
    bit busy;
    int cnt;
    busy = 1'b0;
    cnt = 0;
    while (!masters_done) begin
      @(posedge clk);
      #2;
      m_bus.resp  = 1'b0;
      m_bus.retry = 1'b0;
      if (!m_bus.cyc) busy = 1'b0;
      else if (!busy && m_bus.stb) begin
        busy = 1'b1;
        cnt = $urandom_range(0, 3);
      end
      if (busy) begin
        if (cnt == 0) begin
          if ($urandom_range(0, 5) == 0) m_bus.retry = 1'b1;
          else m_bus.resp = 1'b1;
          m_bus.rdata = {$urandom, $urandom, $urandom, $urandom};
          busy = 1'b0;
        end else cnt--;
      end
    end
    m_bus.resp  = 1'b0;
    m_bus.retry = 1'b0;
  endtask

  logic [DATA_W-1:0] rnd;
  logic              grant_log [8];
  logic [7:0]        order_exp;

  initial begin
    i_bus.addr = '0; i_bus.wdata = '0; i_bus.stb = 1'b0; i_bus.cyc = 1'b0;
    i_bus.we = 1'b0; i_bus.sel = '0;
    d_bus.addr = '0; d_bus.wdata = '0; d_bus.stb = 1'b0; d_bus.cyc = 1'b0;
    d_bus.we = 1'b0; d_bus.sel = '0;
    m_bus.rdata = '0; m_bus.resp = 1'b0; m_bus.retry = 1'b0;
    order_exp = 8'b1110_1110;

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    model_en = 1'b1;
    @(negedge clk);
    check("rst_ctl", {grant_d, m_bus.stb, m_bus.cyc, m_bus.we}, 4'b0000);
    check("rst_addr_sel", {m_bus.addr, m_bus.sel}, 32'h0);
    check("rst_resp", {i_bus.resp, i_bus.retry, d_bus.resp, d_bus.retry}, 4'b0000);

    // I-only read, memory answers 3 cycles after the grant.
    step();
    i_bus.addr = 16'h1000; i_bus.cyc = 1'b1; i_bus.stb = 1'b1;
    step();
    @(negedge clk);
    check("t1_grant", {grant_d, m_bus.stb, m_bus.cyc, m_bus.we}, 4'b0110);
    check("t1_addr", m_bus.addr, 16'h1000);
    check("t1_sel", m_bus.sel, 16'hFFFF);
    step(); step(); step();
    rnd = {$urandom, $urandom, $urandom, $urandom};
    m_bus.rdata = rnd; m_bus.resp = 1'b1;
    @(negedge clk);
    check("t1_resp", {i_bus.resp, d_bus.resp}, 2'b10);
    check("t1_rdata", i_bus.rdata, rnd);
    step();
    m_bus.resp = 1'b0; i_bus.cyc = 1'b0; i_bus.stb = 1'b0;
    @(negedge clk);
    check("t1_idle", {grant_d, m_bus.stb, m_bus.cyc}, 3'b000);

    // D write with partial byte enables.
    step();
    rnd = {$urandom, $urandom, $urandom, $urandom};
    d_bus.addr = 16'h2000; d_bus.wdata = rnd; d_bus.we = 1'b1; d_bus.sel = 16'h00FF;
    d_bus.cyc = 1'b1; d_bus.stb = 1'b1;
    step();
    @(negedge clk);
    check("t2_ctl", {grant_d, m_bus.stb, m_bus.cyc, m_bus.we}, 4'b1111);
    check("t2_sel", m_bus.sel, 16'h00FF);
    check("t2_wdata", m_bus.wdata, rnd);
    check("t2_addr", m_bus.addr, 16'h2000);
    step();
    m_bus.resp = 1'b1; m_bus.rdata = '0;
    @(negedge clk);
    check("t2_resp", {i_bus.resp, d_bus.resp}, 2'b01);
    step();
    m_bus.resp = 1'b0; d_bus.cyc = 1'b0; d_bus.stb = 1'b0;
    @(negedge clk);
    check("t2_idle", {grant_d, m_bus.cyc}, 2'b00);

    // Both sides request continuously: expect D,D,D,I,D,D,D,I.
    step();
    i_bus.addr = 16'h1100; i_bus.cyc = 1'b1; i_bus.stb = 1'b1;
    d_bus.addr = 16'h2200; d_bus.we = 1'b0; d_bus.cyc = 1'b1; d_bus.stb = 1'b1;
    for (int g = 0; g < 8; g++) begin
      step();
      m_bus.resp = 1'b1; m_bus.rdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      grant_log[g] = grant_d & m_bus.stb & ~(~grant_d & ~m_bus.stb);
      step();
      m_bus.resp = 1'b0;
      if (g == 7) begin
        i_bus.cyc = 1'b0; i_bus.stb = 1'b0; d_bus.cyc = 1'b0; d_bus.stb = 1'b0;
      end
    end
    for (int g = 0; g < 8; g++) begin
      check($sformatf("t3_order_%0d", g), grant_log[g], order_exp[7-g]);
    end

    // Retry releases ownership; a still-requesting D is re-granted.
    step();
    d_bus.addr = 16'h3000; d_bus.cyc = 1'b1; d_bus.stb = 1'b1;
    step();
    m_bus.retry = 1'b1;
    @(negedge clk);
    check("t4_retry", {i_bus.retry, d_bus.retry, i_bus.resp, d_bus.resp}, 4'b0100);
    step();
    m_bus.retry = 1'b0;
    @(negedge clk);
    check("t4_idle", {grant_d, m_bus.stb, m_bus.cyc}, 3'b000);
    step();
    @(negedge clk);
    check("t4_regrant", {grant_d, m_bus.stb, m_bus.cyc}, 3'b111);
    step();
    m_bus.resp = 1'b1;
    @(negedge clk);
    check("t4_resp", d_bus.resp, 1'b1);
    step();
    m_bus.resp = 1'b0; d_bus.cyc = 1'b0; d_bus.stb = 1'b0;

    // Owner drops cyc mid-transaction.
    step();
    d_bus.addr = 16'h4000; d_bus.cyc = 1'b1; d_bus.stb = 1'b1;
    step();
    d_bus.cyc = 1'b0;
    @(negedge clk);
    check("t5_abort", {grant_d, m_bus.cyc}, 2'b10);
    step();
    d_bus.stb = 1'b0;
    @(negedge clk);
    check("t5_idle", {grant_d, m_bus.stb, m_bus.cyc}, 3'b000);

    // Reset in the middle of an I transaction.
    step();
    i_bus.addr = 16'h5000; i_bus.cyc = 1'b1; i_bus.stb = 1'b1;
    step();
    @(negedge clk);
    check("t6_granted", {grant_d, m_bus.stb, m_bus.cyc}, 3'b011);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("t6_rst_ctl", {grant_d, m_bus.stb, m_bus.cyc, m_bus.we, m_bus.sel, m_bus.addr}, 36'h0);
    check("t6_rst_wdata", m_bus.wdata, 128'h0);
    check("t6_rst_resp", {i_bus.resp, i_bus.retry, d_bus.resp, d_bus.retry}, 4'b0000);
    step();
    rst_n = 1'b1; i_bus.cyc = 1'b0; i_bus.stb = 1'b0;

    // Spurious memory response with no owner.
    step();
    m_bus.resp = 1'b1; m_bus.rdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check("t7_spurious", {i_bus.resp, d_bus.resp, grant_d, m_bus.stb}, 4'b0000);
    step();
    m_bus.resp = 1'b0;

    // Randomised traffic on both sides against a random-latency memory.
    step();
    fork
      begin
        fork
          i_master(N_TRANS);
          d_master(N_TRANS);
        join
        masters_done = 1'b1;
      end
      mem_slave();
    join

    repeat (5) step();
    check("sb_drain", sb.size(), 0);
`ifdef ARB_STATS_EN
    check("stat_i_grants", stat_i_grants, 16'(mdl_i_grants));
    check("stat_d_grants", stat_d_grants, 16'(mdl_d_grants));
    check("stat_i_wait", stat_i_wait, 16'(mdl_i_wait));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
